// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive bytes into one little-endian instruction word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_out,
    output logic               full
);

    logic [1:0]         idx_q;
    logic [INSTR_W-1:0] word_q;

    // The word is kept across clear so the last written instruction stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
        end else if (load) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_in;
            idx_q                        <= idx_q + 2'd1;
        end
    end

    // Flags the load that completes the word, so the caller can react on the same edge.
    assign full     = load & ~clear & (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_out = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, holding the CPU until the load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int MEM_SIZE = 16,
    parameter  int ADR_W    = 64,
    localparam int CW       = $clog2(MEM_SIZE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CW-1:0]      num_words,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADR_W-1:0]   imem_adr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               cpu_hold,
    output logic [CW-1:0]      word_count
);

    loader_state_t  state_q, state_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW+1:0]  adr_q, adr_d;
    logic [CW-1:0]  clampedLen;
    logic           packClear;
    logic           packLoad;
    logic           packFull;

    assign clampedLen = (num_words > CW'(MEM_SIZE)) ? CW'(MEM_SIZE) : num_words;
    assign packLoad   = (state_q == RECV) & byte_valid;

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (packClear),
        .load     (packLoad),
        .byte_in  (byte_data),
        .word_out (imem_wdata),
        .full     (packFull)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            adr_q   <= adr_d;
        end
    end

    // Outputs decode from the state register only, keeping byte_valid off any output path.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        adr_d      = adr_q;
        packClear  = 1'b0;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    len_d     = clampedLen;
                    count_d   = '0;
                    packClear = 1'b1;
                    state_d   = (clampedLen == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (packFull) begin
                    adr_d   = {count_q, 2'b00};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                count_d = count_q + CW'(1);
                state_d = (count_q + CW'(1) == len_q) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_hold   = busy;
    assign word_count = count_q;
    assign imem_adr   = ADR_W'(adr_q);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: loader writes into a model instruction memory, compared against a byte-level reference.
module tb_imem_loader;

    localparam int MEM_SIZE = 16;
    localparam int ADR_W    = 64;
    localparam int CW       = $clog2(MEM_SIZE + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     num_words = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADR_W-1:0]  imem_adr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic [CW-1:0]     word_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] obsAdr[$];
    logic [31:0] obsData[$];
    logic [7:0]  stimBytes[$];
    logic [31:0] imemModel[MEM_SIZE];

    typedef struct {
        int numWords;
        int gapMax;
        int expWrites;
        int expLastAdr;
    } vec_t;

    vec_t vecs[5];

    imem_loader #(.MEM_SIZE(MEM_SIZE), .ADR_W(ADR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_adr   (imem_adr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Writable instruction memory plus a log of every write strobe seen.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            obsAdr.push_back(imem_adr);
            obsData.push_back(imem_wdata);
            if (imem_adr < 64'(MEM_SIZE * 4))
                imemModel[imem_adr[5:2]] = imem_wdata;
        end
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, ".byte_ready"}, 64'(byte_ready), 0);
        checkVal({tag, ".imem_we"},    64'(imem_we),    0);
        checkVal({tag, ".busy"},       64'(busy),       0);
        checkVal({tag, ".done"},       64'(done),       0);
        checkVal({tag, ".cpu_hold"},   64'(cpu_hold),   0);
        checkVal({tag, ".imem_adr"},   imem_adr,        0);
        checkVal({tag, ".imem_wdata"}, 64'(imem_wdata), 0);
        checkVal({tag, ".word_count"}, 64'(word_count), 0);
    endtask

    function automatic logic [31:0] modelWord(input int i);
        int unsigned w;
        w = int'(stimBytes[4*i]) + int'(stimBytes[4*i+1]) * 256 +
            int'(stimBytes[4*i+2]) * 65536 + int'(stimBytes[4*i+3]) * 16777216;
        return w;
    endfunction

    task automatic startLoad(input int n);
        @(negedge clk);
        start     = 1'b1;
        num_words = CW'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Offers one byte after an idle gap; returns at the negedge following acceptance.
    task automatic pushByte(input logic [7:0] b, input int gap);
        bit wasReady;
        bit accepted;
        for (int g = 0; g < gap; g++) begin
            checkVal("busyInGap", 64'(busy), 1);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        accepted   = 1'b0;
        for (int t = 0; t < 100 && !accepted; t++) begin
            wasReady = byte_ready;
            @(posedge clk);
            accepted = wasReady;
            if (!accepted) @(negedge clk);
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL byteTimeout: got ready=0 for 100 cycles expected ready=1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic compareWrites(input int nWords);
        checkVal("numWrites", 64'(obsAdr.size()), 64'(nWords));
        for (int i = 0; i < nWords && i < obsAdr.size(); i++) begin
            checkVal($sformatf("adr[%0d]", i), obsAdr[i], 64'(4 * i));
            checkVal($sformatf("data[%0d]", i), 64'(obsData[i]), 64'(modelWord(i)));
            checkVal($sformatf("readback[%0d]", i), 64'(imemModel[i]), 64'(modelWord(i)));
        end
    endtask

    // Full load: stimBytes must already hold at least 4*min(n,MEM_SIZE) bytes.
    task automatic runLoad(input int n, input int gapMax);
        int len;
        len = (n > MEM_SIZE) ? MEM_SIZE : n;
        obsAdr.delete();
        obsData.delete();
        startLoad(n);
        if (len == 0) begin
            checkVal("zeroLen.done", 64'(done), 1);
            checkVal("zeroLen.busy", 64'(busy), 0);
        end else begin
            checkVal("load.busy", 64'(busy), 1);
            for (int i = 0; i < 4 * len; i++)
                pushByte(stimBytes[i], (gapMax == 0) ? 0 : $urandom_range(0, gapMax));
            checkVal("lastWe", 64'(imem_we), 1);
            @(negedge clk);
        end
        checkVal("end.done",       64'(done),       1);
        checkVal("end.cpu_hold",   64'(cpu_hold),   0);
        checkVal("end.word_count", 64'(word_count), 64'(len));
        compareWrites(len);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            checkVal("extra.byte_ready", 64'(byte_ready), 0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic loadFixed();
        stimBytes.delete();
        foreach (fixedStream[i]) stimBytes.push_back(fixedStream[i]);
    endtask

    task automatic loadRandom(input int nBytes);
        stimBytes.delete();
        for (int i = 0; i < nBytes; i++) stimBytes.push_back(8'($urandom));
    endtask

    logic [7:0] fixedStream[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    task automatic applyStimulus();
        int n;
        // Reset and idle.
        repeat (2) @(negedge clk);
        checkIdle("inReset");
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkIdle("idle");
        end

        // Known two-instruction program, back-to-back then gapped.
        loadFixed();
        runLoad(2, 0);
        checkVal("fixed.data0", 64'(obsData.size() > 0 ? obsData[0] : 32'hx), 64'h00000013);
        checkVal("fixed.data1", 64'(obsData.size() > 1 ? obsData[1] : 32'hx), 64'h00100093);
        runLoad(2, 2);

        // Table-driven loads including clamp and zero length.
        for (int v = 0; v < 5; v++) begin
            loadRandom(4 * MEM_SIZE);
            runLoad(vecs[v].numWords, vecs[v].gapMax);
            checkVal($sformatf("vec%0d.writes", v), 64'(obsAdr.size()), 64'(vecs[v].expWrites));
            if (vecs[v].expWrites > 0 && obsAdr.size() > 0)
                checkVal($sformatf("vec%0d.lastAdr", v), obsAdr[obsAdr.size()-1], 64'(vecs[v].expLastAdr));
        end

        // Randomized loads.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(0, 20);
            loadRandom(4 * MEM_SIZE);
            runLoad(n, $urandom_range(0, 3));
        end

        // Reset in the middle of a word.
        obsAdr.delete();
        obsData.delete();
        loadFixed();
        startLoad(2);
        pushByte(stimBytes[0], 0);
        pushByte(stimBytes[1], 0);
        #2 reset = 1'b1;
        #1 checkIdle("midReset");
        checkVal("midReset.writes", 64'(obsAdr.size()), 0);
        @(negedge clk);
        reset = 1'b0;
        runLoad(2, 0);

        // start while loading is ignored; zero-length start finishes immediately.
        obsAdr.delete();
        obsData.delete();
        startLoad(2);
        pushByte(stimBytes[0], 0);
        pushByte(stimBytes[1], 0);
        start     = 1'b1;
        num_words = CW'(1);
        @(negedge clk);
        start     = 1'b0;
        checkVal("midStart.busy", 64'(busy), 1);
        for (int i = 2; i < 8; i++) pushByte(stimBytes[i], 0);
        @(negedge clk);
        checkVal("midStart.done", 64'(done), 1);
        checkVal("midStart.word_count", 64'(word_count), 2);
        compareWrites(2);
        startLoad(0);
        checkVal("zeroStart.done", 64'(done), 1);
        checkVal("zeroStart.word_count", 64'(word_count), 0);
        checkVal("zeroStart.writes", 64'(obsAdr.size()), 2);
    endtask

    task automatic checkOutput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        vecs[0] = '{numWords: 1,  gapMax: 0, expWrites: 1,  expLastAdr: 0};
        vecs[1] = '{numWords: 3,  gapMax: 2, expWrites: 3,  expLastAdr: 8};
        vecs[2] = '{numWords: 16, gapMax: 0, expWrites: 16, expLastAdr: 60};
        vecs[3] = '{numWords: 20, gapMax: 1, expWrites: 16, expLastAdr: 60};
        vecs[4] = '{numWords: 0,  gapMax: 0, expWrites: 0,  expLastAdr: 0};
        foreach (imemModel[i]) imemModel[i] = '0;
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
